// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Four-requester round-robin arbiter for the shared 64-bit
//               data-memory port (fetch, load/store, DMA, debug). Grants
//               ownership for multi-beat transfers and drives the select of
//               the shared 4:1 port mux. Carries no data.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous, active-high reset
//               req[3:0]     - per-requester request, held for whole transfer
//               last[3:0]    - per-requester final-beat marker (owner only)
//               mem_ready    - memory accepts the current beat
//               gnt[3:0]     - registered one-hot grant, zero when idle
//               sel[1:0]     - registered mux select, equals owner index
//               mem_valid    - busy & req[sel] (combinational)
//               busy         - registered, high while a grant is held
//               timeout_err  - sticky timeout flag
// Options     : `define ARB_TIMEOUT_EN enables the stall timeout (TIMEOUT
//               cycles without a completed beat forces a release and sets
//               timeout_err). Without it timeout_err is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       mem_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic       busy,
    output logic       timeout_err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("mem_port_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic [1:0] r_ptr;
    logic       r_busy;

    logic [1:0] w_winner;
    logic       w_any;
    logic       w_owner_req;
    logic       w_beat;
    logic       w_release;
    logic       w_timeout_hit;

    // Round-robin scan: first set request starting at r_ptr, wrapping mod 4.
    always_comb begin
        w_winner = r_ptr;
        w_any    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!w_any && req[r_ptr + 2'(i)]) begin
                w_winner = r_ptr + 2'(i);
                w_any    = 1'b1;
            end
        end
    end

    assign w_owner_req = req[r_sel];
    assign mem_valid   = r_busy & w_owner_req;
    assign w_beat      = mem_valid & mem_ready;

    // Release on final beat, on the owner dropping its request (abort), or
    // on a stall timeout.
    assign w_release = (r_state == ST_GRANT) &&
                       (!w_owner_req || (w_beat && last[r_sel]) || w_timeout_hit);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_timeout_limit = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_timeout_err;

    // The counter value is the number of stalled GRANT cycles already seen;
    // reaching TIMEOUT happens on the edge where it would step past
    // TIMEOUT-1. A completed beat clears it instead, so a beat on that same
    // edge wins. An abort on that edge is a plain release with no error.
    assign w_timeout_hit = r_busy && w_owner_req && !w_beat &&
                           (r_cnt == c_timeout_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_GRANT || w_beat || w_release) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // sel is left at the old owner after release; it is only
                    // meaningful while busy.
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_sel + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule
`default_nettype wire
